// File: rtl/aes_shift_rows_packer.sv
// AES forward ShiftRows stage: packs a narrow beat stream into a
// 128-bit state and emits the row-shifted state on a valid/ready port.
module aes_shift_rows_packer #(
    parameter int BEAT_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [127:0]            out_state,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              beat_cnt
);

    localparam int N  = 16 / BEAT_BYTES;
    localparam int BW = 8 * BEAT_BYTES;

    typedef enum logic {
        ST_COLLECT,
        ST_LAST
    } state_e;

    // With a single beat per state every beat closes a state.
    localparam state_e ST_INIT = (N == 1) ? ST_LAST : ST_COLLECT;

    state_e       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [127:0] asm_q, asm_d;
    logic [127:0] out_q, out_d;
    logic         ov_q, ov_d;
    logic         accept;
    logic         drain;
    logic [127:0] merged;

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // The last beat waits only while the output slot is full and stuck.
    assign in_ready = !((cnt_q == 5'(N-1)) && ov_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = ov_q && out_ready;

    // Assembly register with the incoming beat dropped into its slot.
    always_comb begin
        merged = asm_q;
        for (int j = 0; j < N; j++) begin
            if (cnt_q == 5'(j)) begin
                merged[127-BW*j -: BW] = in_data;
            end
        end
    end

    // Next-state logic: clear wins, then drain, then beat acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        out_d   = out_q;
        ov_d    = ov_q;
        if (clear) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            ov_d    = 1'b0;
        end else begin
            if (drain) begin
                ov_d = 1'b0;
            end
            if (accept) begin
                if (state_q == ST_LAST) begin
                    out_d   = shift_rows(merged);
                    ov_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_INIT;
                end else begin
                    asm_d   = merged;
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (int'(cnt_q) == N - 2) ? ST_LAST : ST_COLLECT;
                end
            end
        end
    end

    // State, assembly and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    assign out_state = out_q;
    assign out_valid = ov_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_aes_shift_rows_packer.sv
// Bench for aes_shift_rows_packer: four beat widths, scoreboarded
// against an independent ShiftRows model.
module tb_aes_shift_rows_packer;

    localparam logic [127:0] V1 = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] E1 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] E2 = 128'h00050a0f04090e03080d02070c01060b;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic [3:0]   iv;
    logic [3:0]   ordy;
    logic [3:0]   ordy_eff;
    logic         rnd_en;
    logic         rnd_rdy;
    logic [127:0] ind [4];
    wire  [3:0]   ir;
    wire  [3:0]   ov;
    wire  [127:0] outs [4];
    wire  [4:0]   bc [4];
    int           bb [4] = '{1, 2, 4, 16};
    logic [127:0] sbq [$];
    int           n_pass = 0;
    int           n_tot = 0;

    always #5 clk = ~clk;

    always_comb begin
        ordy_eff = ordy;
        if (rnd_en) ordy_eff[1] = rnd_rdy;
    end

    aes_shift_rows_packer #(.BEAT_BYTES(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(ind[0][7:0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_state(outs[0]), .out_valid(ov[0]),
        .out_ready(ordy_eff[0]), .beat_cnt(bc[0])
    );

    aes_shift_rows_packer #(.BEAT_BYTES(2)) u_b2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(ind[1][15:0]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_state(outs[1]), .out_valid(ov[1]),
        .out_ready(ordy_eff[1]), .beat_cnt(bc[1])
    );

    aes_shift_rows_packer #(.BEAT_BYTES(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(ind[2][31:0]), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_state(outs[2]), .out_valid(ov[2]),
        .out_ready(ordy_eff[2]), .beat_cnt(bc[2])
    );

    aes_shift_rows_packer #(.BEAT_BYTES(16)) u_b16 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(ind[3]), .in_valid(iv[3]), .in_ready(ir[3]),
        .out_state(outs[3]), .out_valid(ov[3]),
        .out_ready(ordy_eff[3]), .beat_cnt(bc[3])
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    function automatic logic [127:0] ref_sr(input logic [127:0] s);
        logic [7:0]   m [4][4];
        logic [127:0] o;
        for (int k = 0; k < 16; k++) m[k%4][k/4] = s[127-8*k -: 8];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o = {o[119:0], m[r][(c+r)%4]};
        return o;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int u, input logic [127:0] d, input bit gap,
                        output int waits);
        int n;
        waits = 0;
        if (gap) begin
            n = int'($urandom_range(0, 2));
            repeat (n) sync();
        end
        ind[u] = d;
        iv[u]  = 1'b1;
        @(negedge clk);
        while (!ir[u] && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (!ir[u]) check("accept_timeout", 128'(ir[u]), 128'd1);
        sync();
        iv[u] = 1'b0;
    endtask

    task automatic send(input int u, input logic [127:0] st, input int nb,
                        input bit gap, output int wt);
        int           w;
        logic [127:0] t;
        wt = 0;
        for (int j = 0; j < nb; j++) begin
            t = st << (8 * bb[u] * j);
            t = t >> (128 - 8 * bb[u]);
            beat(u, t, gap, w);
            wt += w;
        end
    endtask

    // Scoreboard: every output handshake pops one expected state.
    always @(negedge clk) begin
        logic [127:0] e;
        if (rst_n && !clear) begin
            for (int u = 0; u < 4; u++) begin
                if (ov[u] && ordy_eff[u]) begin
                    e = (sbq.size() != 0) ? sbq.pop_front() : ~outs[u];
                    check("out_state", outs[u], e);
                end
            end
        end
    end

    initial begin
        rnd_rdy = 1'b0;
        forever begin
            sync();
            if (rnd_en) rnd_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int           w;
        logic [127:0] st;
        logic [127:0] t;
        rst_n  = 1'b0;
        clear  = 1'b0;
        iv     = '0;
        ordy   = 4'hF;
        rnd_en = 1'b0;
        for (int u = 0; u < 4; u++) ind[u] = '0;

        // reset state
        @(negedge clk);
        check("rst_ov", 128'(ov), 128'd0);
        check("rst_bc1", 128'(bc[0]), 128'd0);
        check("rst_out1", outs[0], 128'd0);
        check("rst_out16", outs[3], 128'd0);
        rst_n = 1'b1;
        sync();
        @(negedge clk);
        check("rst_rdy", 128'(ir), 128'hF);
        sync();

        // byte-serial, consumer always ready
        send(0, V1, 16, 1'b0, w);
        sbq.push_back(E1);
        @(negedge clk);
        check("t1_ov", 128'(ov[0]), 128'd1);
        @(negedge clk);
        check("t1_ov_low", 128'(ov[0]), 128'd0);
        sync();

        // word beats with a stalled consumer
        ordy[2] = 1'b0;
        send(2, V1, 4, 1'b0, w);
        sbq.push_back(E1);
        repeat (3) begin
            @(negedge clk);
            check("t2_hold", outs[2], E1);
            check("t2_ov", 128'(ov[2]), 128'd1);
        end
        sync();
        send(2, V2, 3, 1'b0, w);
        check("t2_nowait", 128'(w), 128'd0);
        t = V2 & 128'hffffffff;
        ind[2] = t;
        iv[2]  = 1'b1;
        @(negedge clk);
        check("t2_block", 128'(ir[2]), 128'd0);
        check("t2_hold2", outs[2], E1);
        sync();
        ordy[2] = 1'b1;
        sbq.push_back(E2);
        @(negedge clk);
        check("t2_rdy", 128'(ir[2]), 128'd1);
        sync();
        iv[2] = 1'b0;
        @(negedge clk);
        check("t2_ov_kept", 128'(ov[2]), 128'd1);
        sync();

        // full-width beats back to back
        for (int i = 0; i < 6; i++) begin
            st = (i == 0) ? V1 : {$urandom, $urandom, $urandom, $urandom};
            send(3, st, 1, 1'b0, w);
            sbq.push_back((i == 0) ? E1 : ref_sr(st));
            check("t3_nowait", 128'(w), 128'd0);
            check("t3_bc", 128'(bc[3]), 128'd0);
        end
        sync();

        // clear mid-state
        send(0, V2, 7, 1'b0, w);
        clear = 1'b1;
        sync();
        clear = 1'b0;
        @(negedge clk);
        check("t4_bc", 128'(bc[0]), 128'd0);
        check("t4_ov", 128'(ov[0]), 128'd0);
        sync();
        send(0, V1, 16, 1'b0, w);
        sbq.push_back(E1);
        repeat (4) sync();
        check("t4_sb", 128'(sbq.size()), 128'd0);

        // async reset with a result pending
        ordy[0] = 1'b0;
        send(0, V2, 16, 1'b0, w);
        @(negedge clk);
        check("t5_pend", 128'(ov[0]), 128'd1);
        sync();
        send(0, V1, 9, 1'b0, w);
        check("t5_bc9", 128'(bc[0]), 128'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ov", 128'(ov[0]), 128'd0);
        check("t5_bc", 128'(bc[0]), 128'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[0] = 1'b1;
        sync();
        send(0, V1, 16, 1'b0, w);
        sbq.push_back(E1);
        repeat (4) sync();

        // random gaps and backpressure on half-word beats
        rnd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            send(1, st, 8, 1'b1, w);
            sbq.push_back(ref_sr(st));
        end
        repeat (4) sync();
        rnd_en = 1'b0;
        repeat (10) sync();
        check("sb_drained", 128'(sbq.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
